// File: rtl/executor_acao_if.sv
// Command/status bundle between the pipe robot controller and its action executor.
interface executor_acao_if #(
    parameter int LINHAS  = 16,
    parameter int COLUNAS = 16
);
    logic [0:2]                   acao;
    logic [$clog2(LINHAS)-1:0]    linha;
    logic [$clog2(COLUNAS)-1:0]   coluna;
    logic                         ocupado;
    logic                         concluido;
    logic                         limpando;
    logic                         erro_borda;
    logic                         erro_cmd;
    logic [7:0]                   num_limpezas;

    modport master (
        output acao,
        input  linha, coluna, ocupado, concluido, limpando,
               erro_borda, erro_cmd, num_limpezas
    );

    modport slave (
        input  acao,
        output linha, coluna, ocupado, concluido, limpando,
               erro_borda, erro_cmd, num_limpezas
    );
endinterface

// File: rtl/executor_acao.sv
// Action executor: turns acao commands into timed grid moves or cleanings,
// tracks row/column position and reports busy/done/error status.
module executor_acao #(
    parameter int LINHAS         = 16,
    parameter int COLUNAS        = 16,
    parameter int LIN_INI        = 0,
    parameter int COL_INI        = 0,
    parameter int PASSO_CICLOS   = 4,
    parameter int LIMPEZA_CICLOS = 8
) (
    input  logic             clockc3,
    input  logic             reset,
    executor_acao_if.slave   bus
);
    localparam int LW   = $clog2(LINHAS);
    localparam int CLW  = $clog2(COLUNAS);
    localparam int MAXC = (PASSO_CICLOS > LIMPEZA_CICLOS) ? PASSO_CICLOS : LIMPEZA_CICLOS;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] MOVENDO  = 2'd1;
    localparam logic [1:0] LIMPANDO = 2'd2;

    localparam logic [2:0] PARADO = 3'b000;
    localparam logic [2:0] ACAO_N = 3'b001;
    localparam logic [2:0] ACAO_O = 3'b010;
    localparam logic [2:0] ACAO_L = 3'b011;
    localparam logic [2:0] ACAO_S = 3'b100;
    localparam logic [2:0] LIMPAR = 3'b101;

    logic [1:0]     estado;
    logic [CW-1:0]  contador;
    logic [2:0]     direcao;
    logic [2:0]     cmd;
    logic           fora;
    logic [LW-1:0]  linha;
    logic [CLW-1:0] coluna;

    // acao is declared [0:2]; this keeps the numeric value of the code.
    assign cmd = bus.acao;

    always_comb begin
        fora = 1'b0;
        case (cmd)
            ACAO_N:  fora = (linha == '0);
            ACAO_S:  fora = (linha == LW'(LINHAS - 1));
            ACAO_O:  fora = (coluna == '0);
            ACAO_L:  fora = (coluna == CLW'(COLUNAS - 1));
            default: fora = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clockc3 or negedge reset) begin
        if (!reset) begin
            estado           <= OCIOSO;
            contador         <= '0;
            direcao          <= PARADO;
            linha            <= LW'(LIN_INI);
            coluna           <= CLW'(COL_INI);
            bus.ocupado      <= 1'b0;
            bus.concluido    <= 1'b0;
            bus.limpando     <= 1'b0;
            bus.erro_borda   <= 1'b0;
            bus.erro_cmd     <= 1'b0;
            bus.num_limpezas <= 8'd0;
        end else begin
            bus.concluido  <= 1'b0;
            bus.erro_borda <= 1'b0;
            bus.erro_cmd   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    case (cmd)
                        PARADO: ;
                        ACAO_N, ACAO_O, ACAO_L, ACAO_S: begin
                            if (fora) begin
                                bus.erro_borda <= 1'b1;
                            end else begin
                                direcao     <= cmd;
                                contador    <= CW'(PASSO_CICLOS - 1);
                                estado      <= MOVENDO;
                                bus.ocupado <= 1'b1;
                            end
                        end
                        LIMPAR: begin
                            contador     <= CW'(LIMPEZA_CICLOS - 1);
                            estado       <= LIMPANDO;
                            bus.ocupado  <= 1'b1;
                            bus.limpando <= 1'b1;
                        end
                        default: bus.erro_cmd <= 1'b1;
                    endcase
                end
                MOVENDO: begin
                    if (contador != '0) begin
                        contador <= contador - CW'(1);
                    end else begin
                        // Target was range-checked on accept, so no wrap is possible.
                        case (direcao)
                            ACAO_N:  linha  <= linha - LW'(1);
                            ACAO_S:  linha  <= linha + LW'(1);
                            ACAO_O:  coluna <= coluna - CLW'(1);
                            ACAO_L:  coluna <= coluna + CLW'(1);
                            default: ;
                        endcase
                        bus.concluido <= 1'b1;
                        bus.ocupado   <= 1'b0;
                        estado        <= OCIOSO;
                    end
                end
                LIMPANDO: begin
                    if (contador != '0) begin
                        contador <= contador - CW'(1);
                    end else begin
                        if (bus.num_limpezas != 8'hFF)
                            bus.num_limpezas <= bus.num_limpezas + 8'd1;
                        bus.concluido <= 1'b1;
                        bus.ocupado   <= 1'b0;
                        bus.limpando  <= 1'b0;
                        estado        <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.linha  = linha;
    assign bus.coluna = coluna;
endmodule

// File: doc/executor_acao.md
# executor_acao

Action executor for the pipe cleaner robot. It consumes the 3-bit `acao` command stream produced by the motion/cleaning controller. It turns each command into a timed grid move or a timed cleaning operation, tracks the robot's row/column position inside the pipe grid, and reports completion, busy and border-violation status back to the controller.

## Interface

Parameters:
- `LINHAS`, 16: number of grid rows; valid rows are 0..LINHAS-1.
- `COLUNAS`, 16: number of grid columns; valid columns are 0..COLUNAS-1.
- `LIN_INI`, 0: row loaded on reset.
- `COL_INI`, 0: column loaded on reset.
- `PASSO_CICLOS`, 4: clock cycles per move step; must be ≥1.
- `LIMPEZA_CICLOS`, 8: clock cycles per cleaning operation; must be ≥1.

Ports:
- `clockc3`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `acao`  in  [0:2]: command code.
  - 000 parado, 001 acaoN, 010 acaoO, 011 acaoL, 100 acaoS, 101 limpar.
  - 110 and 111 are illegal.
- `linha`  out  $clog2(LINHAS): current row.
- `coluna`  out  $clog2(COLUNAS): current column.
- `ocupado`  out  1: a move or cleaning operation is in progress; `acao` is ignored while high.
- `concluido`  out  1: one-cycle pulse when a move or cleaning operation finishes.
- `limpando`  out  1: high while in the cleaning state.
- `erro_borda`  out  1: one-cycle pulse when a move command would leave the grid.
- `erro_cmd`  out  1: one-cycle pulse when an illegal code is sampled.
- `num_limpezas`  out  8: count of completed cleanings; saturates at 255.

## Operation

- States: OCIOSO, MOVENDO, LIMPANDO. The reset state is OCIOSO.
- Reset values:
  - `linha` = LIN_INI, `coluna` = COL_INI.
  - `ocupado`, `concluido`, `limpando`, `erro_borda`, `erro_cmd` = 0.
  - `num_limpezas` = 0.
  - Step counter = 0.
- Direction mapping:
  - N: `linha`-1.
  - S: `linha`+1.
  - L (leste): `coluna`+1.
  - O (oeste): `coluna`-1.
- OCIOSO: `acao` is sampled on every rising edge.
  - 000: stay in OCIOSO, no outputs change.
  - Move code with the target inside the grid:
    - Latch the direction.
    - Load counter = PASSO_CICLOS-1.
    - Go to MOVENDO; `ocupado` = 1.
  - Move code with the target outside the grid (N at row 0, S at row LINHAS-1, O at column 0, L at column COLUNAS-1):
    - Pulse `erro_borda` for one cycle.
    - Stay in OCIOSO; position is unchanged.
  - 101:
    - Load counter = LIMPEZA_CICLOS-1.
    - Go to LIMPANDO; `ocupado` = 1, `limpando` = 1.
  - 110 or 111: pulse `erro_cmd` for one cycle and stay in OCIOSO.
- MOVENDO:
  - Counter > 0: decrement the counter.
  - Counter = 0:
    - Apply the latched direction to the position.
    - Pulse `concluido`.
    - Clear `ocupado`.
    - Return to OCIOSO.
- LIMPANDO:
  - Counter > 0: decrement the counter.
  - Counter = 0:
    - Increment `num_limpezas` (saturating at 255).
    - Pulse `concluido`.
    - Clear `ocupado` and `limpando`.
    - Return to OCIOSO.
- A held move code repeats the move every PASSO_CICLOS+1 cycles until the robot reaches a border. From then on `erro_borda` pulses every cycle while the code stays held.
- A held 101 likewise repeats cleaning every LIMPEZA_CICLOS+1 cycles.
- Reset asserted mid-operation aborts the operation immediately:
  - No `concluido` pulse is produced.
  - Position returns to LIN_INI/COL_INI; it does not keep the partial move.
- The position registers are never written with an out-of-range value.

## Timing

- Command accept: `acao` is sampled at rising edge E0 while in OCIOSO. `ocupado` is high from E0 until edge E0+N, where N = PASSO_CICLOS or LIMPEZA_CICLOS.
- Completion edge E0+N, all together:
  - `linha`/`coluna` (or `num_limpezas`) update.
  - `concluido` rises and stays high for exactly one cycle.
  - `ocupado` falls.
- The earliest next command accept is E0+N+1. The throughput for back-to-back commands is one command per N+1 cycles.
- `erro_borda` and `erro_cmd` are high for the single cycle that follows the sampling edge.
- All outputs are registered. There are no combinational paths from `acao` to any output.

## Test plan

- Reset with LIN_INI = COL_INI = 5, then `acao` = 001 for one cycle.
  - Expected: `ocupado` high for 4 cycles.
  - At edge E0+4: `linha` = 4, `coluna` = 5, and a single `concluido` pulse.
- Position (0,0), `acao` = 001, then 010.
  - Expected: two `erro_borda` pulses.
  - Position stays (0,0); `ocupado` never rises.
- `acao` = 101 held for 20 cycles.
  - Expected: `limpando` high for 8 cycles, low for 1, then high again.
  - `num_limpezas` = 1 at E0+8 and 2 at E0+17.
- Position (5,5), `acao` = 011 held.
  - Expected: `coluna` steps 6..15 at E0+4, E0+9, E0+14, … (every 5 cycles).
  - Then `erro_borda` pulses every cycle.
- Start a move, change `acao` to 100 during `ocupado`, then assert `reset` low at the 2nd busy cycle.
  - Expected: the changed `acao` is ignored.
  - The reset immediately clears `ocupado` and returns the position to (LIN_INI, COL_INI), with no `concluido` pulse.
- `acao` = 111 for one cycle, then 000.
  - Expected: one `erro_cmd` pulse.
  - No state change; all other outputs stay at their idle values.
